// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the L2's L1-side port between the D-cache (req0) and I-cache/prefetch (req1).
// Holds the granted command stable until l2_ready and returns the L2 response as a one-cycle done pulse.
module l2_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned BLOCK_SIZE = 32,
  localparam int unsigned BW = BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_read,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [BW-1:0]         req0_wdata,
  output logic                  req0_done,
  output logic                  req0_hit,
  output logic                  req0_valid,
  output logic [BW-1:0]         req0_rdata,
  input  logic                  req1_read,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [BW-1:0]         req1_wdata,
  output logic                  req1_done,
  output logic                  req1_hit,
  output logic                  req1_valid,
  output logic [BW-1:0]         req1_rdata,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [BW-1:0]         l2_wdata,
  input  logic                  l2_ready,
  input  logic                  l2_hit,
  input  logic                  l2_valid,
  input  logic [BW-1:0]         l2_rdata,
  output logic                  grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   act0;
  logic   act1;
  logic   any_act;
  logic   sel_id;
  logic   rr_next;
  logic   cmd_read;
  logic   cmd_write;

  // Next state, arbitration choice and the masked L2 command strobes.
  always_comb begin
    state_nxt = state;
    act0      = req0_read | req0_write;
    act1      = req1_read | req1_write;
    any_act   = act0 | act1;
    sel_id    = (act0 && act1) ? rr_next : act1;
    l2_read   = 1'b0;
    l2_write  = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_act) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Drop the command in the ready cycle so the L2 does not start a second access.
        l2_read  = cmd_read & ~l2_ready;
        l2_write = cmd_write & ~l2_ready;
        if (l2_ready) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != S_IDLE);

  // Grant capture, command hold and per-requester response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= 1'b0;
      rr_next    <= 1'b0;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
      l2_addr    <= '0;
      l2_wdata   <= '0;
      req0_done  <= 1'b0;
      req0_hit   <= 1'b0;
      req0_valid <= 1'b0;
      req0_rdata <= '0;
      req1_done  <= 1'b0;
      req1_hit   <= 1'b0;
      req1_valid <= 1'b0;
      req1_rdata <= '0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      if (state == S_IDLE && any_act) begin
        grant_id <= sel_id;
        rr_next  <= ~sel_id;
        if (sel_id) begin
          l2_addr   <= req1_addr;
          l2_wdata  <= req1_wdata;
          cmd_write <= req1_write;
          cmd_read  <= req1_read & ~req1_write;
        end else begin
          l2_addr   <= req0_addr;
          l2_wdata  <= req0_wdata;
          cmd_write <= req0_write;
          cmd_read  <= req0_read & ~req0_write;
        end
      end
      if (state == S_WAIT && l2_ready) begin
        if (grant_id) begin
          req1_done  <= 1'b1;
          req1_hit   <= l2_hit;
          req1_valid <= l2_valid;
          req1_rdata <= l2_rdata;
        end else begin
          req0_done  <= 1'b1;
          req0_hit   <= l2_hit;
          req0_valid <= l2_valid;
          req0_rdata <= l2_rdata;
        end
      end
    end
  end

endmodule
